// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm
// Purpose  : Inference sequencer for the 784-32-10 MNIST MLP accelerator.
//            A start request runs one pass. The phases are image load, a
//            layer-1 MAC sweep, a ReLU/bias window, a layer-2 MAC sweep and
//            argmax capture.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active-low
//            start      - level request, sampled only in IDLE or DONE
//            done       - high while in DONE
//            busy       - high in LOAD/COMP_L1/RELU/COMP_L2/MAX
//            layer_sel  - memory layer select (0 idle/load/done, 1 L1,
//                         2 relu/L2, 3 max)
//            row_idx    - row being swept, 0 outside COMP_L1/COMP_L2
//            mac_en_l1/mac_clr_l1/mac_en_l2/mac_clr_l2 - MAC array controls
//            load_img/comp_l1/apply_relu/comp_l2/find_max - phase strobes
//            cycle_cnt  - busy-cycle count of the current/last inference
// Config   : CTRL_FSM_CYCLE_CNT_EN - when defined, cycle_cnt is a live
//            saturating counter. Otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm #(
  parameter int IMG_SIZE = 784,
  parameter int HID_SIZE = 32,
  parameter int RELU_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [1:0] layer_sel,
  output logic [9:0] row_idx,
  output logic       mac_en_l1,
  output logic       mac_clr_l1,
  output logic       mac_en_l2,
  output logic       mac_clr_l2,
  output logic       load_img,
  output logic       comp_l1,
  output logic       apply_relu,
  output logic       comp_l2,
  output logic       find_max,
  output logic [9:0] cycle_cnt
);

  localparam int RELU_W = (RELU_CYC > 1) ? $clog2(RELU_CYC) : 1;

  localparam logic [9:0]        c_l1_last   = 10'(IMG_SIZE - 1);
  localparam logic [9:0]        c_l2_last   = 10'(HID_SIZE - 1);
  localparam logic [RELU_W-1:0] c_relu_last = RELU_W'(RELU_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMP_L1 = 3'd2,
    S_RELU    = 3'd3,
    S_COMP_L2 = 3'd4,
    S_MAX     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [9:0]        r_row_idx;
  logic [9:0]        w_row_nxt;
  logic [RELU_W-1:0] r_relu_cnt;
  logic [RELU_W-1:0] w_relu_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_row_idx  <= '0;
      r_relu_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_row_idx  <= w_row_nxt;
      r_relu_cnt <= w_relu_nxt;
    end
  end

  // Row and ReLU counters default to zero. They only advance inside their
  // own sweep, so every phase entry starts from zero with no extra clearing.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = '0;
    w_relu_nxt  = '0;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_COMP_L1;
      S_COMP_L1: begin
        if (r_row_idx == c_l1_last) w_state_nxt = S_RELU;
        else                        w_row_nxt   = r_row_idx + 10'd1;
      end
      S_RELU: begin
        if (r_relu_cnt == c_relu_last) w_state_nxt = S_COMP_L2;
        else                           w_relu_nxt  = r_relu_cnt + RELU_W'(1);
      end
      S_COMP_L2: begin
        if (r_row_idx == c_l2_last) w_state_nxt = S_MAX;
        else                        w_row_nxt   = r_row_idx + 10'd1;
      end
      S_MAX:     w_state_nxt = S_DONE;
      S_DONE:    if (start) w_state_nxt = S_LOAD;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs, decoded from the registered state only.
  assign load_img   = (r_state == S_LOAD);
  assign comp_l1    = (r_state == S_COMP_L1);
  assign apply_relu = (r_state == S_RELU);
  assign comp_l2    = (r_state == S_COMP_L2);
  assign find_max   = (r_state == S_MAX);
  assign done       = (r_state == S_DONE);
  assign busy       = load_img | comp_l1 | apply_relu | comp_l2 | find_max;
  assign mac_en_l1  = comp_l1;
  assign mac_clr_l1 = load_img;
  assign mac_en_l2  = comp_l2;
  assign mac_clr_l2 = load_img;
  assign row_idx    = r_row_idx;

  always_comb begin
    layer_sel = 2'd0;
    case (r_state)
      S_COMP_L1:        layer_sel = 2'd1;
      S_RELU, S_COMP_L2: layer_sel = 2'd2;
      S_MAX:            layer_sel = 2'd3;
      default:          layer_sel = 2'd0;
    endcase
  end

`ifdef CTRL_FSM_CYCLE_CNT_EN
  logic [9:0] r_cycle_cnt;

  // Clear on entry to LOAD. Count every busy cycle. The count then holds
  // through DONE so software can read the latency of the last inference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
    end else if (w_state_nxt == S_LOAD && !busy) begin
      r_cycle_cnt <= '0;
    end else if (busy && r_cycle_cnt != 10'h3FF) begin
      r_cycle_cnt <= r_cycle_cnt + 10'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  assign cycle_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_fsm
// Purpose  : Self-checking bench for ctrl_fsm. It uses a scoreboard of
//            per-cycle expected phase, row_idx and cycle_cnt values, plus
//            per-cycle strobe and mapping invariants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

  localparam int IMG  = 784;
  localparam int HID  = 32;
  localparam int RELU = 3;

  // Phase vector layout: {done, load_img, comp_l1, apply_relu, comp_l2, find_max}
  localparam logic [5:0] PH_IDLE = 6'b000000;
  localparam logic [5:0] PH_DONE = 6'b100000;
  localparam logic [5:0] PH_LOAD = 6'b010000;
  localparam logic [5:0] PH_L1   = 6'b001000;
  localparam logic [5:0] PH_RELU = 6'b000100;
  localparam logic [5:0] PH_L2   = 6'b000010;
  localparam logic [5:0] PH_MAX  = 6'b000001;

  typedef struct packed {
    logic [5:0] ph;
    logic [9:0] row;
    logic [9:0] cnt;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       done, busy;
  logic [1:0] layer_sel;
  logic [9:0] row_idx, cycle_cnt;
  logic       mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2;
  logic       load_img, comp_l1, apply_relu, comp_l2, find_max;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  logic [4:0] strobes;
  logic [1:0] ls_exp;
  exp_t       e_mon;

  ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .layer_sel  (layer_sel),
    .row_idx    (row_idx),
    .mac_en_l1  (mac_en_l1),
    .mac_clr_l1 (mac_clr_l1),
    .mac_en_l2  (mac_en_l2),
    .mac_clr_l2 (mac_clr_l2),
    .load_img   (load_img),
    .comp_l1    (comp_l1),
    .apply_relu (apply_relu),
    .comp_l2    (comp_l2),
    .find_max   (find_max),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] exp_cnt(input int v);
`ifdef CTRL_FSM_CYCLE_CNT_EN
    return (v > 1023) ? 10'd1023 : 10'(v);
`else
    return 10'd0;
`endif
  endfunction

  task automatic push(input logic [5:0] ph, input int row, input int cnt);
    exp_t e;
    e.ph  = ph;
    e.row = 10'(row);
    e.cnt = exp_cnt(cnt);
    q.push_back(e);
  endtask

  // One full inference seen from the cycle after the edge that samples start.
  task automatic push_run(input int n_done);
    push(PH_LOAD, 0, 0);
    for (int i = 0; i < IMG; i++)  push(PH_L1,   i, 1 + i);
    for (int j = 0; j < RELU; j++) push(PH_RELU, 0, 1 + IMG + j);
    for (int k = 0; k < HID; k++)  push(PH_L2,   k, 1 + IMG + RELU + k);
    push(PH_MAX, 0, 1 + IMG + RELU + HID);
    for (int d = 0; d < n_done; d++) push(PH_DONE, 0, 2 + IMG + RELU + HID);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    strobes = {load_img, comp_l1, apply_relu, comp_l2, find_max};
    if (comp_l1)                     ls_exp = 2'd1;
    else if (apply_relu | comp_l2)   ls_exp = 2'd2;
    else if (find_max)               ls_exp = 2'd3;
    else                             ls_exp = 2'd0;
    check("strobe_onehot", $countones(strobes), busy ? 1 : 0);
    check("busy_vs_strobes", busy, |strobes);
    check("layer_sel_map", layer_sel, ls_exp);
    check("mac_ctrl_map", {mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2},
          {comp_l1, load_img, comp_l2, load_img});
    check("done_busy_excl", done & busy, 0);
    check("row_in_range", row_idx <= 10'(IMG - 1), 1);
    if (!(comp_l1 | comp_l2)) check("row_zero_outside", row_idx, 0);
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      check("phase", {done, load_img, comp_l1, apply_relu, comp_l2, find_max}, e_mon.ph);
      check("row_idx", row_idx, e_mon.row);
      check("cycle_cnt", cycle_cnt, e_mon.cnt);
    end
  end

  initial begin
    // Reset state
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {done, busy, layer_sel, mac_en_l1, mac_clr_l1, mac_en_l2,
          mac_clr_l2, load_img, comp_l1, apply_relu, comp_l2, find_max}, 0);
    check("rst_row", row_idx, 0);
    check("rst_cnt", cycle_cnt, 0);
    rst = 1'b1;
    push(PH_IDLE, 0, 0);
    @(negedge clk);
    push(PH_IDLE, 0, 0);
    @(negedge clk);

    // Single-cycle start pulse from IDLE, then DONE holds with start low
    start = 1'b1;
    push_run(3);
    @(negedge clk);
    start = 1'b0;
    wait_drain(1000);

    // Restart from DONE. A start pulse during COMP_L2 must be ignored.
    start = 1'b1;
    push_run(1);
    @(negedge clk);
    start = 1'b0;
    repeat (789) @(negedge clk);
    check("in_comp_l2_before_pulse", comp_l2, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(1000);

    // Start held high: one inference, done for one cycle, then immediate restart
    start = 1'b1;
    push_run(1);
    push(PH_LOAD, 0, 0);
    for (int i = 0; i <= 100; i++) push(PH_L1, i, 1 + i);
    wait_drain(1100);
    check("pre_rst_row", row_idx, 100);
    check("pre_rst_comp_l1", comp_l1, 1);

    // Asynchronous reset mid COMP_L1
    rst = 1'b0;
    #1;
    check("midrst_outputs", {done, busy, layer_sel, mac_en_l1, mac_clr_l1, mac_en_l2,
          mac_clr_l2, load_img, comp_l1, apply_relu, comp_l2, find_max}, 0);
    check("midrst_row", row_idx, 0);
    check("midrst_cnt", cycle_cnt, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Fresh inference after reset
    push(PH_IDLE, 0, 0);
    @(negedge clk);
    start = 1'b1;
    push_run(2);
    @(negedge clk);
    start = 1'b0;
    wait_drain(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
